mem_stage_lsu: RTL and testbench

- Load/store sequencer between the EX/MEM pipeline register and data_mem.
- Takes one 32-bit load or store request at a time and aligns it to data_mem's 16-bit write port and byte/halfword/word read ports.
- Splits word stores into two halfword writes and sign/zero-extends loads.
- Stalls the pipeline through req_ready until the access completes.

---
 rtl/mem_stage_lsu.sv | 210 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store sequencer between the EX/MEM register and data_mem.
// Define LSU_STATS_EN to build the saturating load/store/misalign counters.
module mem_stage_lsu #(
    parameter int MEM_RD_LAT = 1,
    parameter int LSU_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 misalign_err,
    output logic                 mem_w_enable,
    output logic                 mem_read,
    output logic [31:0]          mem_address,
    output logic [15:0]          mem_data_in,
    output logic [1:0]           mem_byteaccess,
    input  logic [31:0]          mem_data_out,
    input  logic [7:0]           mem_data_out_byte,
    output logic [LSU_CNT_W-1:0] stat_loads,
    output logic [LSU_CNT_W-1:0] stat_stores,
    output logic [LSU_CNT_W-1:0] stat_misalign
);

    typedef enum logic [2:0] {
        IDLE,
        ST_ONE,
        ST_HI,
        ST_LO,
        LD_REQ,
        LD_CAP
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(MEM_RD_LAT - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  cnt;

    logic        req_byte;
    logic        req_half;
    logic        req_misalign;

    always_comb begin
        req_byte     = (req_size == 2'b01);
        req_half     = (req_size == 2'b10);
        req_misalign = 1'b0;
        if (req_half) begin
            req_misalign = req_addr[0];
        end else if (!req_byte) begin
            req_misalign = (req_addr[1:0] != 2'b00);
        end
    end

    function automatic logic [31:0] extend(
        input logic [1:0]  size,
        input logic        sgn,
        input logic [31:0] word,
        input logic [7:0]  byte_in
    );
        logic [31:0] r;
        unique case (size)
            2'b01:   r = {{24{sgn & byte_in[7]}}, byte_in};
            2'b10:   r = {{16{sgn & word[15]}}, word[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    // Mem outputs are loaded with the values of the state being entered,
    // so every mem_* pin comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            misalign_err   <= 1'b0;
            mem_w_enable   <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_data_in    <= '0;
            mem_byteaccess <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            cnt            <= '0;
        end else begin
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_misalign) begin
                            misalign_err <= 1'b1;
                        end else begin
                            addr_q      <= req_addr;
                            wdata_q     <= req_wdata;
                            size_q      <= req_size;
                            signed_q    <= req_signed;
                            req_ready   <= 1'b0;
                            mem_address <= req_addr;
                            if (req_we) begin
                                mem_w_enable <= 1'b1;
                                if (req_byte) begin
                                    state          <= ST_ONE;
                                    mem_data_in    <= {8'h00, req_wdata[7:0]};
                                    mem_byteaccess <= 2'b01;
                                end else if (req_half) begin
                                    state          <= ST_ONE;
                                    mem_data_in    <= req_wdata[15:0];
                                    mem_byteaccess <= 2'b10;
                                end else begin
                                    state          <= ST_HI;
                                    mem_data_in    <= req_wdata[31:16];
                                    mem_byteaccess <= 2'b10;
                                end
                            end else begin
                                state          <= LD_REQ;
                                mem_read       <= 1'b1;
                                mem_byteaccess <= req_size;
                                cnt            <= CNT_INIT;
                            end
                        end
                    end
                end
                ST_HI: begin
                    state       <= ST_LO;
                    mem_address <= addr_q + 32'd2;
                    mem_data_in <= wdata_q[15:0];
                end
                ST_ONE, ST_LO: begin
                    state        <= IDLE;
                    req_ready    <= 1'b1;
                    resp_valid   <= 1'b1;
                    mem_w_enable <= 1'b0;
                end
                LD_REQ: begin
                    if (cnt != 2'd0) begin
                        cnt <= cnt - 2'd1;
                    end else begin
                        state <= LD_CAP;
                    end
                end
                LD_CAP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b1;
                    mem_read   <= 1'b0;
                    resp_rdata <= extend(size_q, signed_q,
                                         mem_data_out, mem_data_out_byte);
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef LSU_STATS_EN
    logic [LSU_CNT_W-1:0] n_ld;
    logic [LSU_CNT_W-1:0] n_st;
    logic [LSU_CNT_W-1:0] n_mis;
    logic                 ld_done;
    logic                 st_done;
    logic                 mis_hit;

    assign ld_done = (state == LD_CAP);
    assign st_done = (state == ST_ONE) || (state == ST_LO);
    assign mis_hit = (state == IDLE) && req_valid && req_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_ld  <= '0;
            n_st  <= '0;
            n_mis <= '0;
        end else begin
            if (ld_done && (n_ld != '1)) begin
                n_ld <= n_ld + 1'b1;
            end
            if (st_done && (n_st != '1)) begin
                n_st <= n_st + 1'b1;
            end
            if (mis_hit && (n_mis != '1)) begin
                n_mis <= n_mis + 1'b1;
            end
        end
    end

    assign stat_loads    = n_ld;
    assign stat_stores   = n_st;
    assign stat_misalign = n_mis;
`else
    assign stat_loads    = '0;
    assign stat_stores   = '0;
    assign stat_misalign = '0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: random and directed checks of mem_stage_lsu against a
// byte-array memory model and a transaction-level reference memory.
module tb_mem_stage_lsu;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int CW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mem_clr;
    logic          req_valid, req_ready, req_we, req_signed;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, misalign_err;
    logic [31:0]   resp_rdata;
    logic          mem_w_enable, mem_read;
    logic [31:0]   mem_address;
    logic [15:0]   mem_data_in;
    logic [1:0]    mem_byteaccess;
    logic [31:0]   mem_data_out;
    logic [7:0]    mem_data_out_byte;
    logic [CW-1:0] stat_loads, stat_stores, stat_misalign;

    logic          b_req_valid, b_req_ready;
    logic          b_resp_valid, b_misalign_err;
    logic [31:0]   b_resp_rdata;
    logic          b_mem_w_enable, b_mem_read;
    logic [31:0]   b_mem_address;
    logic [15:0]   b_mem_data_in;
    logic [1:0]    b_mem_byteaccess;
    logic [31:0]   b_mem_data_out;
    logic [7:0]    b_mem_data_out_byte;
    logic [CW-1:0] b_stat_loads, b_stat_stores, b_stat_misalign;

    mem_stage_lsu #(.MEM_RD_LAT(LAT_A), .LSU_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misalign_err(misalign_err),
        .mem_w_enable(mem_w_enable), .mem_read(mem_read),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_byteaccess(mem_byteaccess),
        .mem_data_out(mem_data_out), .mem_data_out_byte(mem_data_out_byte),
        .stat_loads(stat_loads), .stat_stores(stat_stores),
        .stat_misalign(stat_misalign)
    );

    mem_stage_lsu #(.MEM_RD_LAT(LAT_B), .LSU_CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(1'b0), .req_size(2'b00), .req_signed(1'b0),
        .req_addr(32'h8), .req_wdata(32'h0),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
        .misalign_err(b_misalign_err),
        .mem_w_enable(b_mem_w_enable), .mem_read(b_mem_read),
        .mem_address(b_mem_address), .mem_data_in(b_mem_data_in),
        .mem_byteaccess(b_mem_byteaccess),
        .mem_data_out(b_mem_data_out),
        .mem_data_out_byte(b_mem_data_out_byte),
        .stat_loads(b_stat_loads), .stat_stores(b_stat_stores),
        .stat_misalign(b_stat_misalign)
    );

    int checks = 0;
    int failures = 0;
    int n_ld = 0, n_st = 0, n_mis = 0;

    // mem: what data_mem holds; refm: what the spec says it should hold
    logic [7:0]  mem [256];
    logic [7:0]  refm [256];
    logic [31:0] pb [3];
    logic [7:0]  pbb [3];

    function automatic logic [31:0] mem_rd(input logic [31:0] a,
                                           input logic [1:0] ba);
        logic [7:0]  x;
        logic [31:0] j;
        x = a[7:0];
        j = $urandom();
        case (ba)
            2'b01:   return {j[31:8], mem[x]};
            2'b10:   return {j[31:16], mem[x], mem[x + 8'd1]};
            default: return {mem[x], mem[x + 8'd1], mem[x + 8'd2], mem[x + 8'd3]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_w_enable) begin
            if (mem_byteaccess == 2'b01) begin
                mem[mem_address[7:0]] <= mem_data_in[7:0];
            end else begin
                mem[mem_address[7:0]]        <= mem_data_in[15:8];
                mem[mem_address[7:0] + 8'd1] <= mem_data_in[7:0];
            end
        end
        mem_data_out      <= mem_rd(mem_address, mem_byteaccess);
        mem_data_out_byte <= mem[mem_address[7:0]];
        pb[0]  <= mem_rd(b_mem_address, b_mem_byteaccess);
        pb[1]  <= pb[0];
        pb[2]  <= pb[1];
        pbb[0] <= mem[b_mem_address[7:0]];
        pbb[1] <= pbb[0];
        pbb[2] <= pbb[1];
    end

    assign b_mem_data_out      = pb[2];
    assign b_mem_data_out_byte = pbb[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_load(input logic [1:0] size,
                                             input logic sgn,
                                             input logic [31:0] a);
        logic [7:0]  x;
        logic [15:0] h;
        x = a[7:0];
        h = {refm[x], refm[x + 8'd1]};
        case (size)
            2'b01:   return sgn ? {{24{refm[x][7]}}, refm[x]} : {24'h0, refm[x]};
            2'b10:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: return {refm[x], refm[x + 8'd1], refm[x + 8'd2], refm[x + 8'd3]};
        endcase
    endfunction

    // One transaction; latency counted in samples taken 1ns after each edge,
    // starting at the accept edge, so it is the spec latency minus one.
    task automatic do_op(input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wdata);
        logic        mis, word, bad;
        logic [31:0] exp_rd;
        logic [49:0] ew [$];
        logic [49:0] got [$];
        int          exp_k, k, w;
        word = (size == 2'b00) || (size == 2'b11);
        mis = (size == 2'b10 && addr[0]) || (word && addr[1:0] != 2'b00);
        exp_rd = 32'h0;
        if (mis) exp_k = 0;
        else if (we) exp_k = word ? 2 : 1;
        else exp_k = LAT_A + 1;
        if (!mis && we) begin
            if (size == 2'b01) begin
                ew.push_back({addr, 2'b01, 8'h00, wdata[7:0]});
                refm[addr[7:0]] = wdata[7:0];
            end else if (size == 2'b10) begin
                ew.push_back({addr, 2'b10, wdata[15:0]});
                refm[addr[7:0]]        = wdata[15:8];
                refm[addr[7:0] + 8'd1] = wdata[7:0];
            end else begin
                ew.push_back({addr, 2'b10, wdata[31:16]});
                ew.push_back({addr + 32'd2, 2'b10, wdata[15:0]});
                for (int i = 0; i < 4; i++)
                    refm[addr[7:0] + 8'(i)] = wdata[31 - 8*i -: 8];
            end
        end
        if (!mis && !we) exp_rd = exp_load(size, sgn, addr);
        w = 0;
        while (!req_ready && w < 20) begin
            step();
            w++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL ready_wait: req_ready=%b after %0d cycles, need 1", req_ready, w);
            return;
        end
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_signed = sgn;
        req_addr = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_we = $urandom_range(0, 1);
        req_size = 2'($urandom_range(0, 3));
        req_addr = $urandom();
        req_wdata = $urandom();
        k = 0;
        bad = 1'b0;
        while (!(resp_valid || misalign_err) && k < 20) begin
            if (mem_w_enable) got.push_back({mem_address, mem_byteaccess, mem_data_in});
            if (mem_read && (we || mem_address !== addr || mem_byteaccess !== size))
                bad = 1'b1;
            step();
            k++;
        end
        if (mis && (mem_read || mem_w_enable)) bad = 1'b1;
        if (!mis && (mem_read || mem_w_enable)) bad = 1'b1;
        checks++;
        if (k !== exp_k) begin
            failures++;
            $display("FAIL latency: we=%b size=%b addr=%h got %0d need %0d", we, size, addr, k, exp_k);
        end
        checks++;
        if ({misalign_err, resp_valid} !== (mis ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL completion: misalign_err,resp_valid=%b%b need %b", misalign_err, resp_valid, mis ? 2'b10 : 2'b01);
        end
        checks++;
        if (req_ready !== 1'b1 || bad) begin
            failures++;
            $display("FAIL bus_ready: req_ready=%b bad_mem_activity=%b need 1/0", req_ready, bad);
        end
        if (!mis && !we) begin
            checks++;
            if (resp_rdata !== exp_rd) begin
                failures++;
                $display("FAIL load_data: size=%b sgn=%b addr=%h got %h need %h", size, sgn, addr, resp_rdata, exp_rd);
            end
        end
        checks++;
        if (got != ew) begin
            failures++;
            $display("FAIL writes: %0d writes seen (first %h), need %0d (first %h)", got.size(), got.size() ? got[0] : 50'h0, ew.size(), ew.size() ? ew[0] : 50'h0);
        end
        if (mis) n_mis++;
        else if (we) n_st++;
        else n_ld++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_clr = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        mem_clr = 1'b0;
        for (int i = 0; i < 256; i++) refm[i] = 8'h00;
        checks++;
        if ({req_ready, resp_valid, misalign_err, mem_w_enable, mem_read} !== 5'b10000 ||
            {mem_address, mem_data_in, mem_byteaccess, resp_rdata} !== 82'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b rv=%b me=%b we=%b rd=%b addr=%h din=%h ba=%b rdata=%h need all 0 except ready=1",
                     req_ready, resp_valid, misalign_err, mem_w_enable, mem_read,
                     mem_address, mem_data_in, mem_byteaccess, resp_rdata);
        end
    endtask

    task automatic test_reset_mid_store();
        do_op(1'b1, 2'b00, 1'b0, 32'h20, 32'hAAAABBBB);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_size = 2'b00;
        req_addr = 32'h20;
        req_wdata = 32'h12345678;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_ld = 0;
        n_st = 0;
        n_mis = 0;
        refm[8'h20] = 8'h12;
        refm[8'h21] = 8'h34;
        checks++;
        if ({req_ready, mem_w_enable, mem_read, resp_valid, misalign_err} !== 5'b10000 ||
            {mem_address, mem_data_in, mem_byteaccess, resp_rdata} !== 82'h0) begin
            failures++;
            $display("FAIL reset_mid_st_hi: ready=%b we=%b rd=%b addr=%h din=%h need ready=1 rest 0",
                     req_ready, mem_w_enable, mem_read, mem_address, mem_data_in);
        end
        step();
        checks++;
        if (mem_w_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_st_lo: mem_w_enable=%b need 0", mem_w_enable);
        end
        do_op(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    endtask

    task automatic test_word_store();
        do_op(1'b1, 2'b00, 1'b0, 32'h8, 32'h13370FFA);
        step();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL resp_pulse: resp_valid=%b one cycle later, need 0", resp_valid);
        end
        do_op(1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
        do_op(1'b1, 2'b00, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D);
        do_op(1'b0, 2'b11, 1'b1, 32'hFFFFFFFC, 32'h0);
    endtask

    task automatic test_loads();
        do_op(1'b1, 2'b01, 1'b0, 32'hA, 32'hFFFF12AD);
        do_op(1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
        do_op(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
        do_op(1'b1, 2'b10, 1'b0, 32'h4, 32'h55558001);
        do_op(1'b0, 2'b10, 1'b1, 32'h4, 32'h0);
        do_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    endtask

    task automatic test_misalign();
        do_op(1'b0, 2'b00, 1'b0, 32'h6, 32'h0);
        do_op(1'b1, 2'b10, 1'b0, 32'h9, 32'h1234);
        step();
        checks++;
        if ({misalign_err, resp_valid, mem_w_enable, mem_read} !== 4'b0000) begin
            failures++;
            $display("FAIL misalign_pulse: err=%b rv=%b we=%b rd=%b need 0000", misalign_err, resp_valid, mem_w_enable, mem_read);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b10) a[0] = 1'b0;
                else if (sz != 2'b01) a[1:0] = 2'b00;
            end
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom());
        end
    endtask

    task automatic test_slow_memory();
        logic [31:0] exp;
        int k, rd;
        logic bad;
        exp = exp_load(2'b00, 1'b0, 32'h8);
        b_req_valid = 1'b1;
        step();
        b_req_valid = 1'b0;
        k = 0;
        rd = 0;
        bad = 1'b0;
        while (!b_resp_valid && k < 20) begin
            if (b_mem_read) rd++;
            if (b_req_ready) bad = 1'b1;
            step();
            k++;
        end
        checks++;
        if (k !== LAT_B + 1 || bad) begin
            failures++;
            $display("FAIL slow_latency: %0d samples ready_early=%b need %0d/0", k, bad, LAT_B + 1);
        end
        checks++;
        if (rd < LAT_B || b_resp_rdata !== exp || b_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL slow_load: read_cycles=%0d rdata=%h ready=%b need >=%0d %h 1", rd, b_resp_rdata, b_req_ready, LAT_B, exp);
        end
    endtask

    task automatic test_stats();
        logic [3*CW-1:0] exp;
`ifdef LSU_STATS_EN
        exp = {CW'(n_ld), CW'(n_st), CW'(n_mis)};
`else
        exp = '0;
`endif
        checks++;
        if ({stat_loads, stat_stores, stat_misalign} !== exp) begin
            failures++;
            $display("FAIL stats: ld=%0d st=%0d mis=%0d need %h", stat_loads, stat_stores, stat_misalign, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_clr = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        b_req_valid = 1'b0;
        test_reset();
        test_reset_mid_store();
        test_word_store();
        test_slow_memory();
        test_loads();
        test_misalign();
        test_stats();
        test_back_to_back_random();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
